// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: conditions the device-driven clock/data pins,
// deframes 11-bit frames, resolves the F0 (break) and E0 (extended)
// prefixes and strobes make/break scan codes to the translation stage.
module ps2_scancode_rx #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       scan_ext,
  output logic       scan_valid,
  output logic       scan_release,
  output logic       frame_err
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

  // Odd parity over data plus parity bit: total number of ones must be odd.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          dat_meta_q, dat_meta_d, dat_sync_q, dat_sync_d;
  logic          filt_clk_q, filt_clk_d, filt_prev_q, filt_prev_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  state_t        state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          brk_pend_q, brk_pend_d, ext_pend_q, ext_pend_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          scan_ext_q, scan_ext_d;
  logic          scan_valid_q, scan_valid_d;
  logic          scan_release_q, scan_release_d;
  logic          frame_err_q, frame_err_d;
  logic          fall_edge_s, frame_done_s, frame_ok_s, timeout_s;

  // State register for synchronizers, filter, FSM, datapath and outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_q     <= 1'b1;
      clk_sync_q     <= 1'b1;
      dat_meta_q     <= 1'b1;
      dat_sync_q     <= 1'b1;
      filt_clk_q     <= 1'b1;
      filt_prev_q    <= 1'b1;
      filt_cnt_q     <= '0;
      state_q        <= IDLE;
      bit_cnt_q      <= 4'd0;
      shift_q        <= 10'd0;
      to_cnt_q       <= '0;
      brk_pend_q     <= 1'b0;
      ext_pend_q     <= 1'b0;
      scan_code_q    <= 8'h00;
      scan_ext_q     <= 1'b0;
      scan_valid_q   <= 1'b0;
      scan_release_q <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      clk_meta_q     <= clk_meta_d;
      clk_sync_q     <= clk_sync_d;
      dat_meta_q     <= dat_meta_d;
      dat_sync_q     <= dat_sync_d;
      filt_clk_q     <= filt_clk_d;
      filt_prev_q    <= filt_prev_d;
      filt_cnt_q     <= filt_cnt_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      to_cnt_q       <= to_cnt_d;
      brk_pend_q     <= brk_pend_d;
      ext_pend_q     <= ext_pend_d;
      scan_code_q    <= scan_code_d;
      scan_ext_q     <= scan_ext_d;
      scan_valid_q   <= scan_valid_d;
      scan_release_q <= scan_release_d;
      frame_err_q    <= frame_err_d;
    end
  end

  // Input conditioning: 2-flop synchronizers and the ps2_clk glitch filter.
  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    dat_meta_d  = ps2_data;
    dat_sync_d  = dat_meta_q;
    filt_prev_d = filt_clk_q;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_clk_d = clk_sync_q;
        filt_cnt_d = '0;
      end else begin
        filt_clk_d = filt_clk_q;
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end else begin
      filt_clk_d = filt_clk_q;
      filt_cnt_d = '0;
    end
  end

  assign fall_edge_s = filt_prev_q & ~filt_clk_q;

  // Next-state logic: frame deframing, bit counting and mid-frame timeout.
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    to_cnt_d     = to_cnt_q;
    frame_done_s = 1'b0;
    timeout_s    = 1'b0;
    case (state_q)
      IDLE: begin
        to_cnt_d  = '0;
        bit_cnt_d = 4'd0;
        if (fall_edge_s && !dat_sync_q) begin
          state_d = RECV;
        end else begin
          state_d = IDLE;
        end
      end
      RECV: begin
        if (fall_edge_s) begin
          // An edge in the same cycle as expiry keeps the frame alive.
          to_cnt_d = '0;
          shift_d  = {dat_sync_q, shift_q[9:1]};
          if (bit_cnt_q == 4'd9) begin
            state_d      = CHECK;
            bit_cnt_d    = 4'd0;
            frame_done_s = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (to_cnt_q == TO_LAST) begin
          timeout_s = 1'b1;
          state_d   = IDLE;
          to_cnt_d  = '0;
          bit_cnt_d = 4'd0;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end
      CHECK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Frame check uses the completed shift value so strobes appear during CHECK.
  assign frame_ok_s = odd_parity_ok(shift_d[8:0]) & shift_d[9];

  // Output logic: prefix resolution and one-cycle make/break/error strobes.
  always_comb begin
    scan_code_d    = scan_code_q;
    scan_ext_d     = scan_ext_q;
    brk_pend_d     = brk_pend_q;
    ext_pend_d     = ext_pend_q;
    scan_valid_d   = 1'b0;
    scan_release_d = 1'b0;
    frame_err_d    = 1'b0;
    if (frame_done_s) begin
      if (frame_ok_s) begin
        if (shift_d[7:0] == 8'hF0) begin
          brk_pend_d = 1'b1;
        end else if (shift_d[7:0] == 8'hE0) begin
          ext_pend_d = 1'b1;
        end else begin
          scan_code_d    = shift_d[7:0];
          scan_ext_d     = ext_pend_q;
          scan_release_d = brk_pend_q;
          scan_valid_d   = ~brk_pend_q;
          brk_pend_d     = 1'b0;
          ext_pend_d     = 1'b0;
        end
      end else begin
        frame_err_d = 1'b1;
        brk_pend_d  = 1'b0;
        ext_pend_d  = 1'b0;
      end
    end else if (timeout_s) begin
      frame_err_d = 1'b1;
      brk_pend_d  = 1'b0;
      ext_pend_d  = 1'b0;
    end else begin
      frame_err_d = 1'b0;
    end
  end

  assign scan_code    = scan_code_q;
  assign scan_ext     = scan_ext_q;
  assign scan_valid   = scan_valid_q;
  assign scan_release = scan_release_q;
  assign frame_err    = frame_err_q;

endmodule
